// File: rtl/ahb_lite_sdp_bridge.sv
// ahb_lite_sdp_bridge
//   AHB-Lite slave in front of a simple-dual-port block RAM with a read
//   latency of 1 or 2 clocks. Writes are zero-wait and use byte enables.
//   Reads get wait states for a 2-clock RAM. A read of the word that is being
//   written in the same cycle is handled in one of two ways. Oversized
//   transfers get a two-cycle ERROR response.
//
//   Build option AHB_SDP_BYPASS_EN:
//     defined   - the colliding write data is captured and merged into the read
//                 data, so the read costs no extra wait state.
//     undefined - the read is reissued to the RAM (REREAD), so it costs exactly
//                 one extra wait state.
module ahb_lite_sdp_bridge #(
  parameter int HADDR_WIDTH = 17,
  parameter int HDATA_WIDTH = 32,
  parameter int RD_LATENCY  = 1,
  parameter int BADDR_WIDTH = $clog2(HDATA_WIDTH/8),
  parameter int MADDR_WIDTH = HADDR_WIDTH - BADDR_WIDTH
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [HADDR_WIDTH-1:0]   HADDR,
  input  logic [1:0]               HTRANS,
  input  logic [2:0]               HSIZE,
  input  logic                     HWRITE,
  input  logic [HDATA_WIDTH-1:0]   HWDATA,
  input  logic                     HSEL,
  input  logic                     HREADY,
  output logic [HDATA_WIDTH-1:0]   HRDATA,
  output logic                     HREADYOUT,
  output logic                     HRESP,
  output logic [MADDR_WIDTH-1:0]   wa,
  output logic                     we,
  output logic [HDATA_WIDTH/8-1:0] wbe,
  output logic [HDATA_WIDTH-1:0]   wd,
  output logic [MADDR_WIDTH-1:0]   ra,
  output logic                     re,
  input  logic [HDATA_WIDTH-1:0]   rd
);

  localparam int NBYTES = HDATA_WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_WAIT, S_REREAD, S_ERR1, S_ERR2
  } state_t;

  state_t                   r_state;
  logic                     r_we;
  logic [NBYTES-1:0]        r_wbe;
  logic [MADDR_WIDTH-1:0]   r_wa;
  logic                     r_hreadyout;
  logic                     r_hresp;
  logic                     r_rd;        // current data phase is a read
  logic [MADDR_WIDTH-1:0]   r_ra_hold;   // word address of the read in flight
`ifdef AHB_SDP_BYPASS_EN
  logic [HDATA_WIDTH-1:0]   r_bp_wd;
  logic [NBYTES-1:0]        r_bp_wbe;
`endif

  logic                     w_req;
  logic                     w_acc;
  logic                     w_size_err;
  logic                     w_coll;
  logic [MADDR_WIDTH-1:0]   w_word;
  logic [NBYTES-1:0]        w_wbe;
  logic [HDATA_WIDTH-1:0]   w_rdata;
  logic                     w_unused;

  // Byte lanes covered by a transfer of the given size, aligned down to size
  function automatic logic [NBYTES-1:0] f_wbe(input logic [2:0] size,
                                              input logic [BADDR_WIDTH-1:0] off);
    logic [NBYTES-1:0] m;
    int nb;
    int lo;
    nb = 1 << size;
    lo = int'(off) & ~(nb - 1);
    for (int i = 0; i < NBYTES; i++) m[i] = (i >= lo) && (i < lo + nb);
    return m;
  endfunction

  assign w_unused   = HTRANS[0];
  assign w_req      = HSEL & HREADY & HTRANS[1];
  // Accept only while our own data phase is not stalling the bus
  assign w_acc      = w_req & r_hreadyout;
  assign w_size_err = (8 << HSIZE) > HDATA_WIDTH;
  assign w_word     = HADDR[HADDR_WIDTH-1:BADDR_WIDTH];
  assign w_wbe      = f_wbe(HSIZE, HADDR[BADDR_WIDTH-1:0]);
  // Read address phase on the word whose write is committing this cycle
  assign w_coll     = w_acc & ~HWRITE & ~w_size_err & r_we & (w_word == r_wa);

  assign wa        = r_wa;
  assign we        = r_we;
  assign wbe       = r_wbe;
  assign wd        = HWDATA;
  assign ra        = (r_state == S_REREAD) ? r_ra_hold : w_word;
  assign re        = (w_acc & ~HWRITE & ~w_size_err) | (r_state == S_REREAD);
  assign HREADYOUT = r_hreadyout;
  assign HRESP     = r_hresp;

`ifdef AHB_SDP_BYPASS_EN
  // Overlay the captured write bytes onto the stale RAM data
  always_comb begin
    w_rdata = rd;
    for (int i = 0; i < NBYTES; i++)
      if (r_bp_wbe[i]) w_rdata[8*i +: 8] = r_bp_wd[8*i +: 8];
  end
`else
  assign w_rdata = rd;
`endif

  assign HRDATA = (r_state == S_DATA && r_rd) ? w_rdata : '0;

  // Transfer FSM with registered bus response and RAM write controls
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_wbe       <= '0;
      r_wa        <= '0;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
      r_rd        <= 1'b0;
      r_ra_hold   <= '0;
`ifdef AHB_SDP_BYPASS_EN
      r_bp_wd     <= '0;
      r_bp_wbe    <= '0;
`endif
    end else begin
      case (r_state)
        S_WAIT: begin
          r_state     <= S_DATA;
          r_hreadyout <= 1'b1;
        end
        S_REREAD: begin
          if (RD_LATENCY == 2) begin
            r_state <= S_WAIT;
          end else begin
            r_state     <= S_DATA;
            r_hreadyout <= 1'b1;
          end
        end
        S_ERR1: begin
          r_state     <= S_ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 can all take a new address phase
          r_state     <= S_IDLE;
          r_we        <= 1'b0;
          r_rd        <= 1'b0;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b0;
          if (w_acc) begin
            if (w_size_err) begin
              r_state     <= S_ERR1;
              r_hreadyout <= 1'b0;
              r_hresp     <= 1'b1;
            end else if (HWRITE) begin
              r_state <= S_DATA;
              r_we    <= 1'b1;
              r_wa    <= w_word;
              r_wbe   <= w_wbe;
            end else begin
              r_rd      <= 1'b1;
              r_ra_hold <= w_word;
`ifdef AHB_SDP_BYPASS_EN
              r_bp_wbe <= w_coll ? r_wbe : '0;
              if (w_coll) r_bp_wd <= HWDATA;
              r_state     <= (RD_LATENCY == 2) ? S_WAIT : S_DATA;
              r_hreadyout <= (RD_LATENCY != 2);
`else
              if (w_coll) begin
                r_state     <= S_REREAD;
                r_hreadyout <= 1'b0;
              end else begin
                r_state     <= (RD_LATENCY == 2) ? S_WAIT : S_DATA;
                r_hreadyout <= (RD_LATENCY != 2);
              end
`endif
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_lite_sdp_bridge.sv
// Bench for ahb_lite_sdp_bridge: two instances (RD_LATENCY 1 and 2), each with
// its own behavioural SDP RAM. A pipelined AHB master runs transaction lists;
// results are scored against a byte-level reference memory.
module tb_ahb_lite_sdp_bridge;

  localparam int NU = 2;
  localparam int K_IDLE = 0, K_WR = 1, K_RD = 2, K_ERR = 3;
`ifdef AHB_SDP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [16:0] haddr     [NU];
  logic [1:0]  htrans    [NU];
  logic [2:0]  hsize     [NU];
  logic        hwrite    [NU];
  logic [31:0] hwdata    [NU];
  logic        hsel      [NU];
  logic [31:0] hrdata    [NU];
  logic        hreadyout [NU];
  logic        hresp     [NU];
  logic [14:0] wa        [NU];
  logic        we        [NU];
  logic [3:0]  wbe       [NU];
  logic [31:0] wd        [NU];
  logic [14:0] ra        [NU];
  logic        re        [NU];
  logic [31:0] rd        [NU];

  for (genvar g = 0; g < NU; g++) begin : g_unit
    logic [31:0] mem [0:32767];
    logic [31:0] q1, q2;

    ahb_lite_sdp_bridge #(
      .HADDR_WIDTH(17), .HDATA_WIDTH(32), .RD_LATENCY(g + 1)
    ) u_dut (
      .HCLK(clk), .HRESETn(rst_n), .HADDR(haddr[g]), .HTRANS(htrans[g]),
      .HSIZE(hsize[g]), .HWRITE(hwrite[g]), .HWDATA(hwdata[g]), .HSEL(hsel[g]),
      .HREADY(hreadyout[g]), .HRDATA(hrdata[g]), .HREADYOUT(hreadyout[g]),
      .HRESP(hresp[g]), .wa(wa[g]), .we(we[g]), .wbe(wbe[g]), .wd(wd[g]),
      .ra(ra[g]), .re(re[g]), .rd(rd[g])
    );

    // SDP RAM: read-during-write returns old data, latency g+1
    always_ff @(posedge clk) begin
      if (we[g])
        for (int i = 0; i < 4; i++)
          if (wbe[g][i]) mem[wa[g]][8*i +: 8] <= wd[g][8*i +: 8];
      if (re[g]) q1 <= mem[ra[g]];
      q2 <= q1;
    end
    assign rd[g] = (g == 0) ? q1 : q2;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // transaction list and per-transaction observations
  int          nt = 0;
  int          t_kind  [64];
  logic [16:0] t_addr  [64];
  logic [2:0]  t_size  [64];
  logic [31:0] t_wdata [64];
  int          t_waits [64];
  logic [31:0] t_rdata [64];
  logic        t_rf    [64];
  logic        t_rl    [64];
  logic        t_we    [64];
  logic [3:0]  t_wbe   [64];
  bit          ramact;

  logic [7:0]  ref_b [int];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic add(input int kind, input int addr, input int size, input logic [31:0] data);
    t_kind[nt]  = kind;
    t_addr[nt]  = 17'(addr);
    t_size[nt]  = 3'(size);
    t_wdata[nt] = data;
    nt++;
  endtask

  task automatic drive_addr(input int u, input int k);
    if (k >= nt || t_kind[k] == K_IDLE) begin
      htrans[u] = 2'b00;
    end else begin
      htrans[u] = 2'b10;
      haddr[u]  = t_addr[k];
      hsize[u]  = t_size[k];
      hwrite[u] = (t_kind[k] == K_WR);
    end
  endtask

  // Pipelined master: address of txn cur overlaps data phase of txn dp
  task automatic run_burst(input int u);
    int cur, dp, ncyc, guard;
    bit done;
    cur = 0; dp = -1; ncyc = 0; guard = 0; done = 0; ramact = 0;
    @(posedge clk); #1;
    while (!done) begin
      drive_addr(u, cur);
      hwdata[u] = (dp >= 0 && t_kind[dp] == K_WR) ? t_wdata[dp] : $urandom;
      @(negedge clk);
      ramact = ramact | we[u] | re[u];
      if (dp >= 0) begin
        if (ncyc == 0) begin
          t_rf[dp] = hresp[u]; t_we[dp] = we[u]; t_wbe[dp] = wbe[u];
        end
        ncyc++;
      end
      if (hreadyout[u]) begin
        if (dp >= 0) begin
          t_rdata[dp] = hrdata[u]; t_rl[dp] = hresp[u]; t_waits[dp] = ncyc - 1;
        end
        if (cur >= nt) done = 1;
        else begin dp = cur; cur++; ncyc = 0; end
      end
      guard++;
      if (!done && guard > 400) begin
        check_eq("burst_timeout", 32'(guard), 32'd0);
        done = 1;
      end
      @(posedge clk); #1;
    end
    htrans[u] = 2'b00;
  endtask

  // Reference: sequential memory semantics, waits from latency and collisions
  task automatic score(input int u);
    int nb, base, a, ew;
    logic [3:0]  ewbe;
    logic [31:0] expd;
    bit coll;
    string tg;
    for (int k = 0; k < nt; k++) begin
      tg = $sformatf("u%0d t%0d", u, k);
      case (t_kind[k])
        K_IDLE: begin
          check_eq({tg, " idle waits"}, 32'(t_waits[k]), 32'd0);
          check_eq({tg, " idle resp"}, 32'(t_rl[k]), 32'd0);
          check_eq({tg, " idle rdata"}, t_rdata[k], 32'd0);
        end
        K_ERR: begin
          check_eq({tg, " err waits"}, 32'(t_waits[k]), 32'd1);
          check_eq({tg, " err resp1"}, 32'(t_rf[k]), 32'd1);
          check_eq({tg, " err resp2"}, 32'(t_rl[k]), 32'd1);
          check_eq({tg, " err rdata"}, t_rdata[k], 32'd0);
        end
        K_WR: begin
          ewbe = 4'b0000;
          nb = 1 << t_size[k];
          base = int'(t_addr[k]) & ~(nb - 1);
          for (int b = 0; b < nb; b++) begin
            a = base + b;
            ewbe[a % 4] = 1'b1;
            ref_b[(u << 20) + a] = t_wdata[k][8*(a % 4) +: 8];
          end
          check_eq({tg, " wr waits"}, 32'(t_waits[k]), 32'd0);
          check_eq({tg, " wr resp"}, 32'(t_rl[k]), 32'd0);
          check_eq({tg, " wr we"}, 32'(t_we[k]), 32'd1);
          check_eq({tg, " wr wbe"}, 32'(t_wbe[k]), 32'(ewbe));
          check_eq({tg, " wr rdata"}, t_rdata[k], 32'd0);
        end
        default: begin
          coll = (k > 0) && (t_kind[k-1] == K_WR) && (t_addr[k-1][16:2] == t_addr[k][16:2]);
          ew = u + ((coll && !BYP) ? 1 : 0);
          base = int'(t_addr[k]) & ~3;
          for (int l = 0; l < 4; l++) begin
            a = (u << 20) + base + l;
            expd[8*l +: 8] = ref_b.exists(a) ? ref_b[a] : 8'h00;
          end
          check_eq({tg, " rd waits"}, 32'(t_waits[k]), 32'(ew));
          check_eq({tg, " rd resp"}, 32'(t_rl[k]), 32'd0);
          check_eq({tg, " rd data"}, t_rdata[k], expd);
        end
      endcase
    end
  endtask

  task automatic rand_burst(input int u, input int n);
    int r, sz;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      sz = $urandom_range(0, 2);
      if (r == 0)      add(K_IDLE, 0, 0, 32'h0);
      else if (r == 1) add(K_ERR, 'h300 + $urandom_range(0, 15), $urandom_range(3, 7), 32'h0);
      else if (r < 6)  add(K_WR, 'h300 + $urandom_range(0, 15), sz, $urandom);
      else             add(K_RD, 'h300 + $urandom_range(0, 15), sz, 32'h0);
    end
    run_burst(u); score(u); nt = 0;
  endtask

  initial begin
    for (int u = 0; u < NU; u++) begin
      hsel[u] = 1'b1; htrans[u] = 2'b00; haddr[u] = '0;
      hsize[u] = 3'd2; hwrite[u] = 1'b0; hwdata[u] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < NU; u++) begin
      check_eq($sformatf("u%0d rst hreadyout", u), 32'(hreadyout[u]), 32'd1);
      check_eq($sformatf("u%0d rst hresp", u), 32'(hresp[u]), 32'd0);
      check_eq($sformatf("u%0d rst we", u), 32'(we[u]), 32'd0);
      check_eq($sformatf("u%0d rst wbe", u), 32'(wbe[u]), 32'd0);
      check_eq($sformatf("u%0d rst wa", u), 32'(wa[u]), 32'd0);
    end
    rst_n = 1'b1;

    for (int u = 0; u < NU; u++) begin
      // word write then non-adjacent read
      add(K_WR, 'h100, 2, 32'hDEADBEEF); add(K_IDLE, 0, 0, 0); add(K_RD, 'h100, 2, 0);
      run_burst(u); score(u);
      check_eq($sformatf("u%0d t1 data", u), t_rdata[2], 32'hDEADBEEF);
      check_eq($sformatf("u%0d t1 waits", u), 32'(t_waits[2]), 32'(u));
      nt = 0;
      // byte write into an existing word
      add(K_WR, 'h100, 2, 32'h11223344); add(K_IDLE, 0, 0, 0);
      add(K_WR, 'h103, 0, 32'h8B8B8B8B); add(K_IDLE, 0, 0, 0); add(K_RD, 'h100, 2, 0);
      run_burst(u); score(u);
      check_eq($sformatf("u%0d t2 wbe", u), 32'(t_wbe[2]), 32'h8);
      check_eq($sformatf("u%0d t2 data", u), t_rdata[4], 32'h8B223344);
      nt = 0;
      // halfword write immediately followed by a read of the same word
      add(K_WR, 'h200, 2, 32'h55555555); add(K_IDLE, 0, 0, 0);
      add(K_WR, 'h200, 1, 32'hAAAAAAAA); add(K_RD, 'h200, 2, 0);
      run_burst(u); score(u);
      check_eq($sformatf("u%0d t3 data", u), t_rdata[3], 32'h5555AAAA);
      check_eq($sformatf("u%0d t3 waits", u), 32'(t_waits[3]), 32'(u + (BYP ? 0 : 1)));
      nt = 0;
      // oversized transfer
      add(K_ERR, 'h40, 3, 0); add(K_IDLE, 0, 0, 0);
      run_burst(u); score(u);
      check_eq($sformatf("u%0d t4 ram access", u), 32'(ramact), 32'd0);
      nt = 0;
      // back-to-back reads
      add(K_WR, 'h0, 2, 32'hA0A0A0A0); add(K_WR, 'h4, 2, 32'hB1B1B1B1);
      add(K_WR, 'h8, 2, 32'hC2C2C2C2); add(K_IDLE, 0, 0, 0);
      add(K_RD, 'h0, 2, 0); add(K_RD, 'h4, 2, 0); add(K_RD, 'h8, 2, 0);
      run_burst(u); score(u);
      check_eq($sformatf("u%0d t5 rd0", u), t_rdata[4], 32'hA0A0A0A0);
      check_eq($sformatf("u%0d t5 rd1", u), t_rdata[5], 32'hB1B1B1B1);
      check_eq($sformatf("u%0d t5 rd2", u), t_rdata[6], 32'hC2C2C2C2);
      nt = 0;
      // randomized traffic over a small, collision-prone window
      for (int w = 0; w < 4; w++) add(K_WR, 'h300 + 4 * w, 2, $urandom);
      run_burst(u); score(u); nt = 0;
      for (int b = 0; b < 3; b++) rand_burst(u, 20);
    end

    // reset dropped during a RD_LATENCY=2 wait state
    @(posedge clk); #1;
    haddr[1] = 17'h100; hsize[1] = 3'd2; hwrite[1] = 1'b0; htrans[1] = 2'b10;
    @(posedge clk); #1;
    htrans[1] = 2'b00;
    check_eq("t6 in wait", 32'(hreadyout[1]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6 rst hreadyout", 32'(hreadyout[1]), 32'd1);
    check_eq("t6 rst hresp", 32'(hresp[1]), 32'd0);
    check_eq("t6 rst we", 32'(we[1]), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    add(K_WR, 'h104, 2, 32'hCAFEF00D); add(K_IDLE, 0, 0, 0); add(K_RD, 'h104, 2, 0);
    run_burst(1); score(1);
    check_eq("t6 after rst data", t_rdata[2], 32'hCAFEF00D);
    nt = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
